rs_cdb_wakeup: RTL

- Small reservation station on the consumer side of the CDB broadcast.
- Holds dispatched instructions whose source operands may still be pending physical-register tags.
- Snoops the CDB every cycle, capturing broadcast values into waiting operands, and issues operand-complete entries to EX with a valid/ready handshake.
- Sits between dispatch and the EX stage; the CDB output packet's reg_tag.tag, reg_tag.valid and reg_value drive the cdb_* inputs.

---
 rtl/rs_cdb_wakeup.sv | 138 +++++++++++++
 1 files changed

// File: rtl/rs_cdb_wakeup.sv
// Reservation station: holds dispatched ops, captures CDB broadcasts into pending
// operands, and issues the lowest-index operand-complete entry over valid/ready.
module rs_cdb_wakeup #(
   parameter int NUM_ENTRIES = 4,
   parameter int TAG_W       = 6,
   parameter int DATA_W      = 32,
   parameter int OP_W        = 32
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           squash,
   input  logic                           dispatch_valid,
   input  logic [OP_W-1:0]                dispatch_payload,
   input  logic [TAG_W-1:0]               dispatch_dest_tag,
   input  logic [TAG_W-1:0]               dispatch_src1_tag,
   input  logic [TAG_W-1:0]               dispatch_src2_tag,
   input  logic                           dispatch_src1_ready,
   input  logic                           dispatch_src2_ready,
   input  logic [DATA_W-1:0]              dispatch_src1_value,
   input  logic [DATA_W-1:0]              dispatch_src2_value,
   input  logic                           cdb_valid,
   input  logic [TAG_W-1:0]               cdb_tag,
   input  logic [DATA_W-1:0]              cdb_value,
   input  logic                           issue_ready,
   output logic                           issue_valid,
   output logic [OP_W-1:0]                issue_payload,
   output logic [TAG_W-1:0]               issue_dest_tag,
   output logic [DATA_W-1:0]              issue_src1_value,
   output logic [DATA_W-1:0]              issue_src2_value,
   output logic                           full,
   output logic [$clog2(NUM_ENTRIES):0]   free_count
);

   localparam int IDX_W = $clog2(NUM_ENTRIES);
   localparam int CNT_W = IDX_W + 1;

   typedef struct packed {
      logic              valid;
      logic [OP_W-1:0]   payload;
      logic [TAG_W-1:0]  dest;
      logic [TAG_W-1:0]  tag1;
      logic [TAG_W-1:0]  tag2;
      logic              rdy1;
      logic              rdy2;
      logic [DATA_W-1:0] val1;
      logic [DATA_W-1:0] val2;
   } entry_t;

   entry_t [NUM_ENTRIES-1:0] ent_q, ent_d;

   logic [NUM_ENTRIES-1:0] free_vec, rdy_vec;
   logic [IDX_W-1:0]       alloc_idx, iss_idx;
   logic [CNT_W-1:0]       free_cnt;
   entry_t                 new_ent;

   // Downward scans so the lowest matching index is the one that sticks.
   always_comb begin
      free_vec  = '0;
      rdy_vec   = '0;
      alloc_idx = '0;
      iss_idx   = '0;
      free_cnt  = '0;
      for (int i = NUM_ENTRIES-1; i >= 0; i--) begin
         free_vec[i] = !ent_q[i].valid;
         rdy_vec[i]  = ent_q[i].valid && ent_q[i].rdy1 && ent_q[i].rdy2;
         free_cnt    = free_cnt + CNT_W'(free_vec[i]);
         if (free_vec[i]) alloc_idx = IDX_W'(i);
         if (rdy_vec[i])  iss_idx   = IDX_W'(i);
      end
   end

   assign full        = ~|free_vec;
   assign free_count  = free_cnt;
   assign issue_valid = |rdy_vec;

   always_comb begin
      issue_payload    = '0;
      issue_dest_tag   = '0;
      issue_src1_value = '0;
      issue_src2_value = '0;
      if (issue_valid) begin
         issue_payload    = ent_q[iss_idx].payload;
         issue_dest_tag   = ent_q[iss_idx].dest;
         issue_src1_value = ent_q[iss_idx].val1;
         issue_src2_value = ent_q[iss_idx].val2;
      end
   end

   // Incoming entry, with same-cycle CDB capture for operands not yet known.
   always_comb begin
      new_ent         = '0;
      new_ent.valid   = 1'b1;
      new_ent.payload = dispatch_payload;
      new_ent.dest    = dispatch_dest_tag;
      new_ent.tag1    = dispatch_src1_tag;
      new_ent.tag2    = dispatch_src2_tag;
      new_ent.rdy1    = dispatch_src1_ready;
      new_ent.rdy2    = dispatch_src2_ready;
      new_ent.val1    = dispatch_src1_value;
      new_ent.val2    = dispatch_src2_value;
      if (!dispatch_src1_ready && cdb_valid && cdb_tag == dispatch_src1_tag) begin
         new_ent.rdy1 = 1'b1;
         new_ent.val1 = cdb_value;
      end
      if (!dispatch_src2_ready && cdb_valid && cdb_tag == dispatch_src2_tag) begin
         new_ent.rdy2 = 1'b1;
         new_ent.val2 = cdb_value;
      end
   end

   always_comb begin
      ent_d = ent_q;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         if (ent_q[i].valid && cdb_valid) begin
            if (!ent_q[i].rdy1 && ent_q[i].tag1 == cdb_tag) begin
               ent_d[i].rdy1 = 1'b1;
               ent_d[i].val1 = cdb_value;
            end
            if (!ent_q[i].rdy2 && ent_q[i].tag2 == cdb_tag) begin
               ent_d[i].rdy2 = 1'b1;
               ent_d[i].val2 = cdb_value;
            end
         end
      end
      if (issue_valid && issue_ready) ent_d[iss_idx].valid = 1'b0;
      // Allocated slot was invalid pre-edge, so it never collides with the issued one.
      if (dispatch_valid && !full) ent_d[alloc_idx] = new_ent;
      if (squash) begin
         for (int i = 0; i < NUM_ENTRIES; i++) ent_d[i].valid = 1'b0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) ent_q <= '0;
      else       ent_q <= ent_d;
   end

endmodule
